// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin arbiter and sequencer placing two requesters in front of one
// shared combinational ALU. One operation is in flight at a time:
//   accept (IDLE) -> operands registered onto alu_a/b/s (EXEC, ALU settles)
//   -> result captured into rsp_data and held for the granted requester (RESP).
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (bit n = requester n)
//   req_a0/b0/s0          operands/opcode of requester 0
//   req_a1/b1/s1          operands/opcode of requester 1
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_data              captured ALU result, shared by both requesters
//   alu_a/alu_b/alu_s     registered operands/opcode driven to the external ALU
//   alu_y                 combinational ALU result
//
// Optional feature macro: ALU_ARB_STATS_EN
//   When defined, adds stat_cnt0/stat_cnt1: saturating 16-bit counts of
//   completed response handshakes per requester, cleared by rst.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int W  = 16,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [W-1:0]  req_a0,
  input  logic [W-1:0]  req_b0,
  input  logic [SW-1:0] req_s0,
  input  logic [W-1:0]  req_a1,
  input  logic [W-1:0]  req_b1,
  input  logic [SW-1:0] req_s1,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [SW-1:0] alu_s,
  input  logic [W-1:0]  alu_y
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cnt0,
  output logic [15:0]   stat_cnt1
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;      // requester favoured on contention
  logic          gnt_q, gnt_d;      // requester owning the in-flight op
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [SW-1:0] s_q, s_d;
  logic [W-1:0]  y_q, y_d;

  logic          gnt_sel;
  logic [1:0]    ready_c;
  logic          accept;

  // Grant selection: the pointer only matters when both requesters are
  // valid; a lone requester wins regardless of the pointer.
  always_comb begin
    if (req_valid == 2'b11) begin
      gnt_sel = ptr_q;
    end else begin
      gnt_sel = req_valid[1];
    end
  end

  // req_ready is gated by rst so it reads as 0 while reset is applied,
  // matching the reset value of every other output.
  always_comb begin
    ready_c = 2'b00;
    if ((state_q == ST_IDLE) && !rst && req_valid[gnt_sel]) begin
      ready_c = gnt_sel ? 2'b10 : 2'b01;
    end
  end

  assign accept    = |(req_valid & ready_c);
  assign req_ready = ready_c;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gnt_d   = gnt_sel;
          ptr_d   = ~gnt_sel;
          a_d     = gnt_sel ? req_a1 : req_a0;
          b_d     = gnt_sel ? req_b1 : req_b0;
          s_d     = gnt_sel ? req_s1 : req_s0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // alu_a/b/s have been stable for this whole cycle.
        y_d     = alu_y;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Only the owning requester's rsp_ready can retire the response.
        if (rsp_ready[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      y_q     <= y_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_s     = s_q;
  assign rsp_data  = y_q;
  assign rsp_valid = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef ALU_ARB_STATS_EN
  logic rsp_done;
  assign rsp_done = (state_q == ST_RESP) && rsp_ready[gnt_q];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (rsp_done && (gnt_q == 1'(gi)) && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign stat_cnt0 = g_stat[0].cnt_q;
  assign stat_cnt1 = g_stat[1].cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed phases (reset, single op, backpressure, reset mid-op, contention)
// followed by a randomized phase. The stimulus process predicts grants from
// the arbitration rules and pushes expected responses into a scoreboard; an
// independent negedge monitor checks every response the DUT presents.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int W  = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic [SW-1:0] req_s0, req_s1;
  logic [W-1:0]  rsp_data, alu_a, alu_b, alu_y;
  logic [SW-1:0] alu_s;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   stat_cnt0, stat_cnt1;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_s0(req_s0),
    .req_a1(req_a1), .req_b1(req_b1), .req_s1(req_s1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  // Behavioural ALU standing in for the external ALU001.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [SW-1:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return b;
    endcase
  endfunction

  always_comb alu_y = alu_fn(alu_a, alu_b, alu_s);

  typedef struct {
    int            id;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] s;
    logic [W-1:0]  y;
    int            acc;
  } op_t;

  op_t        sb[$];
  int         g_log[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  int         hold_mode = 0;   // 0: drop valid after accept, 1: re-present, 2: random
  int         m_done[2];
  logic [1:0] exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_op(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] s);
    if (n == 0) begin
      req_a0 = a; req_b0 = b; req_s0 = s;
    end else begin
      req_a1 = a; req_b1 = b; req_s1 = s;
    end
  endtask

  task automatic rand_op(input int n);
    set_op(n, W'($urandom), W'($urandom), SW'($urandom));
  endtask

  // One clock cycle. Entered and left 1 time unit after a rising edge.
  task automatic step(input bit zero_chk);
    int  g;
    op_t o;
    #2;
    if (rst || sb.size() != 0)    exp_ready = 2'b00;
    else if (req_valid == 2'b11)  exp_ready = (m_ptr == 0) ? 2'b01 : 2'b10;
    else                          exp_ready = req_valid;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (zero_chk) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_s", 32'(alu_s), 32'd0);
    end
    @(posedge clk);
    g = -1;
    if (rst) begin
      sb.delete();
      m_ptr     = 0;
      m_done[0] = 0;
      m_done[1] = 0;
    end else if ((exp_ready & req_valid) != 2'b00) begin
      g     = exp_ready[1] ? 1 : 0;
      o.id  = g;
      o.a   = g ? req_a1 : req_a0;
      o.b   = g ? req_b1 : req_b0;
      o.s   = g ? req_s1 : req_s0;
      o.y   = alu_fn(o.a, o.b, o.s);
      o.acc = cyc;
      sb.push_back(o);
      g_log.push_back(g);
      m_ptr = 1 - g;
    end
    cyc++;
    #1;
    if (g >= 0) begin
      if (hold_mode == 1) rand_op(g);
      else req_valid[g] = 1'b0;
    end
    if (hold_mode == 2) begin
      rsp_ready = 2'($urandom);
      for (int n = 0; n < 2; n++) begin
        if (!req_valid[n]) begin
          req_valid[n] = 1'($urandom);
          rand_op(n);
        end
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    logic [1:0] ev;
    if (!rst) begin
      ev = 2'b00;
      if (sb.size() != 0) begin
        if (cyc == sb[0].acc + 1) begin
          chk("alu_a", 32'(alu_a), 32'(sb[0].a));
          chk("alu_b", 32'(alu_b), 32'(sb[0].b));
          chk("alu_s", 32'(alu_s), 32'(sb[0].s));
        end
        if (cyc >= sb[0].acc + 2) ev = (sb[0].id == 1) ? 2'b10 : 2'b01;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev != 2'b00) begin
        chk("rsp_data", 32'(rsp_data), 32'(sb[0].y));
        if (rsp_ready[sb[0].id]) begin
          if (m_done[sb[0].id] < 65535) m_done[sb[0].id]++;
          sb.pop_front();
        end
      end
    end
  end

  initial begin
    m_done[0] = 0;
    m_done[1] = 0;
    // Reset with random inputs for 2 cycles.
    rst       = 1'b1;
    req_valid = 2'($urandom);
    rsp_ready = 2'($urandom);
    rand_op(0);
    rand_op(1);
    @(posedge clk);
    #1;
    step(1'b0);
    step(1'b1);
    rst       = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(1'b0);

    // Single op from requester 0.
    hold_mode = 0;
    set_op(0, 16'h8888, 16'h1234, 3'b000);
    req_valid = 2'b01;
    step(1'b0);
    step(1'b0);
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", 32'(rsp_data), 32'h9ABC);
    step(1'b0);
    step(1'b0);

    // Backpressure on requester 1.
    rand_op(1);
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b0);
    rsp_ready = 2'b11;
    step(1'b0);
    step(1'b0);

    // Reset in EXEC drops the op.
    rand_op(0);
    req_valid = 2'b01;
    step(1'b0);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    step(1'b1);

    // Contention from reset: strict 0,1,0,1.
    g_log.delete();
    hold_mode = 1;
    rand_op(0);
    rand_op(1);
    req_valid = 2'b11;
    for (int i = 0; i < 13; i++) step(1'b0);
    chk("contention_ops", 32'(g_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < g_log.size(); i++) chk("grant_order", 32'(g_log[i]), 32'(i % 2));

    // Randomized traffic.
    hold_mode = 2;
    for (int i = 0; i < 400; i++) step(1'b0);

    // Drain.
    hold_mode = 0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) step(1'b0);
    chk("drained", 32'(sb.size()), 32'd0);

`ifdef ALU_ARB_STATS_EN
    chk("stat_cnt0", 32'(stat_cnt0), 32'(m_done[0]));
    chk("stat_cnt1", 32'(stat_cnt1), 32'(m_done[1]));
    // Saturation: preload and complete one more op on requester 0.
    force dut.g_stat[0].cnt_q = 16'hFFFF;
    #1;
    release dut.g_stat[0].cnt_q;
    m_done[0] = 65535;
    rand_op(0);
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) step(1'b0);
    chk("stat_sat", 32'(stat_cnt0), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
